// File: rtl/memwb_stage.sv
// -----------------------------------------------------------------------------
// memwb_stage - memory / writeback stage of the 5-stage RV32I pipeline.
//
// Runs the load/store handshake with data memory, places store data on the
// correct byte lanes, sizes and extends load data, selects the writeback
// result and registers it into the W outputs that feed the register file.
// MemStall is combinational so the upstream stages freeze in the same cycle
// that an access is still waiting for mem_ready.
//
// Optional build macro: MEMWB_CHECK_EN
//   When defined, misaligned halfword/word accesses are not issued and a
//   saturating wait counter forces completion after TIMEOUT_CYCLES wait
//   cycles. Both events set the sticky mem_err flag. When undefined, mem_err
//   is tied low and an access may wait indefinitely.
// -----------------------------------------------------------------------------
module memwb_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // memory-stage control and data
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  RdM,
  input  logic [31:0] inc_PCM,
  // data memory interface
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  // pipeline control
  output logic        MemStall,
  // writeback outputs
  output logic        RegWriteW,
  output logic [4:0]  RdW,
  output logic [31:0] ResultW,
  output logic        mem_err
);

  // The wait counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("memwb_stage: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t      state_q, state_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;

  logic        is_load;
  logic        access;
  logic        in_wait;
  logic [1:0]  off;
  logic        misaligned;
  logic        timeout;
  logic        req_live;
  logic        issue;
  logic        stall;
  logic        bubble;
  logic [3:0]  strb;
  logic [31:0] wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] sel_result;

  assign is_load = (ResultSrcM == 2'b01);
  assign access  = is_load | MemWriteM;
  assign in_wait = (state_q == S_WAIT);
  assign off     = ALUResultM[1:0];

`ifdef MEMWB_CHECK_EN
  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q;

  // A new access is refused when its address is not naturally aligned.
  assign misaligned = access & ~in_wait &
                      ((((funct3M == F3_H) | (funct3M == F3_HU)) & off[0]) |
                       ((funct3M == F3_W) & (off != 2'b00)));
  assign timeout    = in_wait & (wait_cnt_q >= TimeoutLimit);
`else
  assign misaligned = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Once in WAIT the request stays up until completion, independent of the
  // M inputs (which upstream holds stable anyway).
  assign req_live = (access & ~misaligned) | in_wait;
  assign issue    = req_live & ~timeout;
  assign stall    = issue & ~mem_ready;
  assign bubble   = stall | misaligned | timeout;

  // Store byte-lane strobes and replicated write data.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    strb  = 4'b1111;
    wdata = WriteDataM;
    case (funct3M)
      F3_B: begin
        strb  = 4'b0001 << off;
        wdata = {4{WriteDataM[7:0]}};
      end
      F3_H: begin
        strb  = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        strb  = 4'b1111;
        wdata = WriteDataM;
      end
    endcase
  end

  // Memory-side outputs; request and strobes are forced low during reset.
  assign mem_req   = rst_n & issue;
  assign mem_we    = rst_n & issue & MemWriteM;
  assign mem_wstrb = mem_we ? strb : 4'b0000;
  assign mem_addr  = {ALUResultM[31:2], 2'b00};
  assign mem_wdata = wdata;
  assign MemStall  = rst_n & stall;

  // Load data lane extraction and sign/zero extension.
  assign load_byte = mem_rdata[{off, 3'b000} +: 8];
  assign load_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_data = mem_rdata;
    case (funct3M)
      F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
      F3_BU:   load_data = {24'h000000, load_byte};
      F3_H:    load_data = {{16{load_half[15]}}, load_half};
      F3_HU:   load_data = {16'h0000, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Writeback result select.
  always_comb begin
    sel_result = ALUResultM;
    case (ResultSrcM)
      2'b01:   sel_result = load_data;
      2'b10:   sel_result = inc_PCM;
      default: sel_result = ALUResultM;
    endcase
  end

  // Next W-register contents: M values on completion, a bubble otherwise.
  always_comb begin
    reg_write_d = RegWriteM;
    rd_d        = RdM;
    result_d    = sel_result;
    if (bubble) begin
      reg_write_d = 1'b0;
      rd_d        = 5'd0;
      result_d    = result_q;
    end
  end

  // FSM: stay in WAIT exactly while an issued access is not yet ready.
  assign state_d = stall ? S_WAIT : S_IDLE;

  // State and writeback register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      result_q    <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
    end
  end

`ifdef MEMWB_CHECK_EN
  // Wait counter: starts at 1 on entering WAIT, saturates at the limit.
  always_comb begin
    wait_cnt_d = 8'd0;
    if (state_d == S_WAIT) begin
      if (!in_wait)
        wait_cnt_d = 8'd1;
      else if (wait_cnt_q >= TimeoutLimit)
        wait_cnt_d = wait_cnt_q;
      else
        wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Wait counter register and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (misaligned | timeout)
        err_q <= 1'b1;
    end
  end

  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign RegWriteW = reg_write_q;
  assign RdW       = rd_q;
  assign ResultW   = result_q;

endmodule

// File: tb/tb_memwb_stage.sv
// -----------------------------------------------------------------------------
// tb_memwb_stage - self-checking bench for memwb_stage.
// Zero-wait accesses come from a vector table; wait-state loads, reset during
// WAIT and (when MEMWB_CHECK_EN is defined) the error checks are hand-written
// sequences. Expected writeback values go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_memwb_stage;

  logic        clk;
  logic        rst_n;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] inc_PCM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        MemStall;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        mem_err;

  memwb_stage #(.TIMEOUT_CYCLES(255)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .inc_PCM    (inc_PCM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .MemStall   (MemStall),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        chk_res;
  } wb_exp_t;

  wb_exp_t sb[$];

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_res;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] rdata,
                       input logic rdy);
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    RdM        = rd;
    inc_PCM    = pc;
    mem_rdata  = rdata;
    mem_ready  = rdy;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 2'b00, 1'b0, 3'b010, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic push(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                      input logic chk_res);
    wb_exp_t e;
    e.rw = rw;
    e.rd = rd;
    e.res = res;
    e.chk_res = chk_res;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    wb_exp_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
      check({tag, " RdW"}, 32'(RdW), 32'(e.rd));
      if (e.chk_res) check({tag, " ResultW"}, ResultW, e.res);
    end
  endtask

  function automatic vec_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                              input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] pc, input logic [31:0] rdata,
                              input logic e_req, input logic e_we,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata,
                              input logic [31:0] e_res);
    vec_t v;
    v.rw = rw; v.rs = rs; v.mw = mw; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.rd = rd; v.pc = pc; v.rdata = rdata; v.e_req = e_req; v.e_we = e_we;
    v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_res = e_res;
    return v;
  endfunction

  // Load with nwait not-ready cycles followed by a ready cycle.
  task automatic wait_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [4:0] rd, input int nwait,
                           input logic [31:0] exp_res);
    drive(1'b1, 2'b01, 1'b0, f3, addr, 32'd0, rd, 32'd0, rdata, 1'b0);
    for (int k = 0; k < nwait; k++) begin
      #1;
      check($sformatf("%s w%0d MemStall", tag, k), 32'(MemStall), 32'd1);
      check($sformatf("%s w%0d mem_req", tag, k), 32'(mem_req), 32'd1);
      check($sformatf("%s w%0d mem_addr", tag, k), mem_addr, {addr[31:2], 2'b00});
      push(1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      pop_check($sformatf("%s w%0d bubble", tag, k));
    end
    mem_ready = 1'b1;
    #1;
    check({tag, " done MemStall"}, 32'(MemStall), 32'd0);
    check({tag, " done mem_req"}, 32'(mem_req), 32'd1);
    push(1'b1, rd, exp_res, 1'b1);
    tick();
    pop_check({tag, " done"});
  endtask

  initial begin
    #2ms;
    $display("FAIL sim_timeout: got no finish expected finish before 2ms");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Vector table: all zero-wait (mem_ready=1).
    //           rw    rs     mw    f3      addr          wd            rd     pc        rdata         req   we    strb     wdata         result
    vecs[0]  = mk(1'b1, 2'b01, 1'b0, 3'b010, 32'h100,      32'h0,        5'd5,  32'h0,    32'hDEADBEEF, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF);
    vecs[1]  = mk(1'b1, 2'b01, 1'b0, 3'b001, 32'h102,      32'h0,        5'd6,  32'h0,    32'h80017FFF, 1'b1, 1'b0, 4'b0000, 32'h0,        32'hFFFF8001);
    vecs[2]  = mk(1'b1, 2'b01, 1'b0, 3'b101, 32'h100,      32'h0,        5'd7,  32'h0,    32'h8001F00F, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000F00F);
    vecs[3]  = mk(1'b1, 2'b01, 1'b0, 3'b000, 32'h101,      32'h0,        5'd8,  32'h0,    32'h00007F00, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0000007F);
    vecs[4]  = mk(1'b1, 2'b01, 1'b0, 3'b100, 32'h102,      32'h0,        5'd9,  32'h0,    32'h00AB0000, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h000000AB);
    vecs[5]  = mk(1'b0, 2'b00, 1'b1, 3'b001, 32'h202,      32'h1234ABCD, 5'd0,  32'h0,    32'h0,        1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 32'h00000202);
    vecs[6]  = mk(1'b0, 2'b00, 1'b1, 3'b000, 32'h301,      32'h000000EE, 5'd0,  32'h0,    32'h0,        1'b1, 1'b1, 4'b0010, 32'hEEEEEEEE, 32'h00000301);
    vecs[7]  = mk(1'b0, 2'b00, 1'b1, 3'b010, 32'h400,      32'hCAFEF00D, 5'd0,  32'h0,    32'h0,        1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 32'h00000400);
    vecs[8]  = mk(1'b1, 2'b10, 1'b0, 3'b000, 32'h0,        32'h0,        5'd1,  32'h44,   32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        32'h00000044);
    vecs[9]  = mk(1'b1, 2'b00, 1'b0, 3'b000, 32'h12345678, 32'h0,        5'd7,  32'h88,   32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        32'h12345678);
    vecs[10] = mk(1'b1, 2'b11, 1'b0, 3'b000, 32'hA5A5A5A4, 32'h0,        5'd3,  32'h88,   32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        32'hA5A5A5A4);
    vecs[11] = mk(1'b1, 2'b00, 1'b0, 3'b000, 32'h00000ABC, 32'h0,        5'd0,  32'h0,    32'h0,        1'b0, 1'b0, 4'b0000, 32'h0,        32'h00000ABC);

    // Reset with an access pending on the inputs: outputs must be gated.
    rst_n = 1'b0;
    drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h100, 32'h0, 5'd4, 32'h0, 32'h0, 1'b0);
    #12;
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst MemStall", 32'(MemStall), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst RegWriteW", 32'(RegWriteW), 32'd0);
    check("rst RdW", 32'(RdW), 32'd0);
    check("rst ResultW", ResultW, 32'd0);
    check("rst mem_err", 32'(mem_err), 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven zero-wait vectors.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rw, vecs[i].rs, vecs[i].mw, vecs[i].f3, vecs[i].addr,
            vecs[i].wd, vecs[i].rd, vecs[i].pc, vecs[i].rdata, 1'b1);
      #1;
      check($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      check($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_strb));
      check($sformatf("v%0d mem_addr", i), mem_addr, {vecs[i].addr[31:2], 2'b00});
      check($sformatf("v%0d MemStall", i), 32'(MemStall), 32'd0);
      if (vecs[i].e_we)
        check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      push(vecs[i].rw, vecs[i].rd, vecs[i].e_res, 1'b1);
      tick();
      pop_check($sformatf("v%0d", i));
    end

    // Three-wait LB / LBU at 0x103 with the top byte 0x80.
    wait_load("lb3", 3'b000, 32'h103, 32'h80123456, 5'd10, 3, 32'hFFFFFF80);
    wait_load("lbu3", 3'b100, 32'h103, 32'h80123456, 5'd11, 3, 32'h00000080);

    // Reset pulsed during WAIT aborts the access.
    drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h500, 32'h0, 5'd12, 32'h0, 32'h11111111, 1'b0);
    #1;
    check("rstw MemStall", 32'(MemStall), 32'd1);
    push(1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    pop_check("rstw bubble");
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw mem_req", 32'(mem_req), 32'd0);
    check("rstw MemStall", 32'(MemStall), 32'd0);
    check("rstw RegWriteW", 32'(RegWriteW), 32'd0);
    check("rstw ResultW", ResultW, 32'd0);
    idle_inputs();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rstw idle mem_req", 32'(mem_req), 32'd0);
    // Back in IDLE: a zero-wait load completes normally.
    drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h600, 32'h0, 5'd13, 32'h0, 32'h0BADF00D, 1'b1);
    #1;
    check("post MemStall", 32'(MemStall), 32'd0);
    push(1'b1, 5'd13, 32'h0BADF00D, 1'b1);
    tick();
    pop_check("post");

`ifdef MEMWB_CHECK_EN
    begin
      int n;
      // Misaligned LW is refused.
      drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h101, 32'h0, 5'd14, 32'h0, 32'h12345678, 1'b1);
      #1;
      check("mis mem_req", 32'(mem_req), 32'd0);
      check("mis MemStall", 32'(MemStall), 32'd0);
      push(1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      pop_check("mis");
      check("mis mem_err", 32'(mem_err), 32'd1);
      // Clear the sticky flag, then time out a never-ready load.
      rst_n = 1'b0;
      #1;
      check("clr mem_err", 32'(mem_err), 32'd0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      drive(1'b1, 2'b01, 1'b0, 3'b010, 32'h700, 32'h0, 5'd15, 32'h0, 32'h0, 1'b0);
      #1;
      n = 0;
      while (mem_req === 1'b1 && n < 300) begin
        n++;
        @(posedge clk);
        #1;
      end
      check("tmo req cycles", 32'(n), 32'd255);
      check("tmo MemStall", 32'(MemStall), 32'd0);
      idle_inputs();
      tick();
      check("tmo RegWriteW", 32'(RegWriteW), 32'd0);
      check("tmo mem_err", 32'(mem_err), 32'd1);
    end
`else
    check("noerr mem_err", 32'(mem_err), 32'd0);
`endif

    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memwb_stage.md
Name: memwb_stage

Overview:
- Memory/writeback stage of the 5-stage RV32I pipeline.
- Takes memory-stage control and data and runs the load/store handshake with data memory.
- Sizes and extends load data, selects the result, and registers it into the writeback outputs (RegWriteW, RdW, ResultW) that drive the decode stage's register-file write port.
- Produces a memory stall to freeze the upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: wait-cycle limit before the watchdog fires (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- RegWriteM  input  1  memory-stage register-write enable
- ResultSrcM  input  2  result select: 00 ALU, 01 load data, 10 inc_PC
- MemWriteM  input  1  store enable
- funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  input  32  effective address / ALU result
- WriteDataM  input  32  store data (unaligned, in low bits)
- RdM  input  5  destination register
- inc_PCM  input  32  PC+4 for JAL/JALR
- mem_req  output  1  memory access request
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned address ({ALUResultM[31:2],2'b00})
- mem_wdata  output  32  store data shifted to byte lane
- mem_wstrb  output  4  byte-lane write strobes
- mem_rdata  input  32  read data (valid when mem_ready)
- mem_ready  input  1  access complete this cycle
- MemStall  output  1  freezes PC, F/D, D/E and E/M registers
- RegWriteW  output  1  writeback enable to register file
- RdW  output  5  writeback destination
- ResultW  output  32  writeback data
- mem_err  output  1  sticky error flag (optional feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; RegWriteW=0, RdW=0, ResultW=0, mem_err=0. mem_req, MemStall, mem_we and mem_wstrb are combinationally 0 while in reset.
- Access = (ResultSrcM==01) or MemWriteM.
- FSM state IDLE:
  - No access: mem_req=0, MemStall=0; W register loads the M values next edge.
  - Access: mem_req=1 the same cycle.
  - Access and mem_ready=1 (zero-wait): complete; MemStall=0; W register loads.
  - Access and mem_ready=0: go to WAIT; MemStall=1; W register loads a bubble (RegWriteW=0, RdW=0).
- FSM state WAIT:
  - mem_req=1 with identical address, data and strobes; upstream holds the M inputs stable.
  - MemStall = ~mem_ready.
  - On mem_ready: W register loads, return to IDLE.
  - On each edge without mem_ready: W register loads a bubble again.
- MemStall is combinational: access & ~mem_ready. It has no registered latency; upstream samples it the same cycle.
- Store lanes (off = ALUResultM[1:0]):
  - SB: wstrb = 0001<<off; wdata = {4{WriteDataM[7:0]}}.
  - SH: wstrb = 0011<<(off[1]*2); wdata = {2{WriteDataM[15:0]}}.
  - SW: wstrb = 1111; wdata = WriteDataM.
  - Loads: wstrb = 0000, mem_we = 0.
- Load extract: pick byte/half by off from mem_rdata. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- ResultW = mux(ResultSrcM): ALUResultM / extracted load / inc_PCM. ResultSrcM = 11 gives ALUResultM.
- Latency: M inputs to W outputs is 1 cycle plus memory wait cycles.
- Misaligned access without the optional feature: low address bits are ignored for halves and words (treated as word/half aligned down).
- Reset asserted during WAIT: FSM returns to IDLE immediately and mem_req drops. No writeback occurs for the aborted access.
- RdM=0 with RegWriteM=1 is passed through unchanged; the register file ignores x0 writes.

Optional Feature:
- Macro: MEMWB_CHECK_EN.
- Defined:
  - Misaligned LH/LHU/SH (off[0]=1) or LW/SW (off!=00) is not issued: mem_req stays 0, the write is suppressed, RegWriteW=0 for that instruction, mem_err set.
  - A WAIT-cycle counter (8 bits, saturating at TIMEOUT_CYCLES) forces completion at the limit: mem_req drops, bubble written, mem_err set, return to IDLE.
  - mem_err stays sticky until reset.
- Undefined: no checks, no counter, mem_err tied 0, FSM may stay in WAIT indefinitely.

Test Plan:
- Zero-wait LW: addr 0x100, mem_rdata 0xDEADBEEF, mem_ready=1, RdM=5, RegWriteM=1 -> next cycle RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, MemStall never high.
- 3-wait LB: addr 0x103, mem_rdata 0x80xxxxxx, mem_ready high on the 4th cycle -> MemStall=1 for 3 cycles with RegWriteW=0 bubbles, then ResultW=0xFFFFFF80. Repeat with LBU -> ResultW=0x00000080.
- SH to addr 0x202, WriteDataM 0x1234ABCD -> mem_we=1, mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
- JAL path: ResultSrcM=10, inc_PCM=0x44, RdM=1 -> mem_req=0, ResultW=0x44, RegWriteW=1.
- rst_n pulsed low during WAIT -> RegWriteW=0, mem_req=0 immediately; state IDLE after release.
- With MEMWB_CHECK_EN: LW at 0x101 -> mem_req=0, RegWriteW=0, mem_err=1. Load with mem_ready held low -> completion forced after 255 cycles, mem_err=1.
